// File: rtl/dmem_controller_rr.sv
// dmem_controller_rr: round-robin memory controller between NUM_CONSUMERS requesters and
// NUM_CHANNELS memory channels, with per-channel busy status.
// Optional watchdog: define DMEMC_TIMEOUT_EN to add a per-channel timer that answers a stalled
// request with read data 0 and a consumer_error flag after TIMEOUT_CYCLES wait cycles.
module dmem_controller_rr #(
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 8,
    parameter int NUM_CONSUMERS  = 4,
    parameter int NUM_CHANNELS   = 2,
    parameter int WRITE_ENABLE   = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_CONSUMERS-1:0]            consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]            consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]            consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]            consumer_write_ready,
`ifdef DMEMC_TIMEOUT_EN
    output logic [NUM_CONSUMERS-1:0]            consumer_error,
`endif
    output logic [NUM_CHANNELS-1:0]             mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]   mem_read_address,
    input  logic [NUM_CHANNELS-1:0]             mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]   mem_read_data,
    output logic [NUM_CHANNELS-1:0]             mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]   mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]   mem_write_data,
    input  logic [NUM_CHANNELS-1:0]             mem_write_ready,
    output logic [NUM_CHANNELS-1:0]             channel_busy
);

    localparam int CW = $clog2(NUM_CONSUMERS);

    typedef enum logic [1:0] {StIdle, StReadWait, StWriteWait, StRelay} ch_state_t;

    ch_state_t                        state_q [NUM_CHANNELS];
    logic [CW-1:0]                    cons_q  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]          is_read_q;
    logic [NUM_CONSUMERS-1:0]         in_service_q;
    logic [CW-1:0]                    rr_ptr_q;
    logic [CW-1:0]                    rr_next;
    logic [NUM_CONSUMERS-1:0]         eligible;
    logic [NUM_CHANNELS-1:0]          grant_en;
    logic [CW-1:0]                    grant_idx [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]          write_valid_q;
    logic [NUM_CHANNELS*ADDR_BITS-1:0] write_address_q;
    logic [NUM_CHANNELS*DATA_BITS-1:0] write_data_q;
    logic [NUM_CONSUMERS-1:0]         write_ready_q;
`ifdef DMEMC_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]                      timer_q [NUM_CHANNELS];
`endif

    // Write requests never become eligible in a read-only build.
    assign eligible = (consumer_read_valid |
                       ((WRITE_ENABLE != 0) ? consumer_write_valid : '0)) & ~in_service_q;

    // Read-only build ties the whole write path to zero.
    assign mem_write_valid      = (WRITE_ENABLE != 0) ? write_valid_q   : '0;
    assign mem_write_address    = (WRITE_ENABLE != 0) ? write_address_q : '0;
    assign mem_write_data       = (WRITE_ENABLE != 0) ? write_data_q    : '0;
    assign consumer_write_ready = (WRITE_ENABLE != 0) ? write_ready_q   : '0;

    // Busy whenever a channel is outside IDLE.
    always_comb begin
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            channel_busy[ch] = (state_q[ch] != StIdle);
        end
    end

    // Idle channels, lowest index first, each claim the next eligible consumer from rr_ptr.
    always_comb begin
        logic [NUM_CONSUMERS-1:0] taken;
        int idx;
        taken    = '0;
        idx      = 0;
        rr_next  = rr_ptr_q;
        grant_en = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            grant_idx[ch] = '0;
            if (state_q[ch] == StIdle) begin
                for (int k = 0; k < NUM_CONSUMERS; k++) begin
                    idx = int'(rr_ptr_q) + k;
                    if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
                    if (!grant_en[ch] && eligible[idx] && !taken[idx]) begin
                        grant_en[ch]  = 1'b1;
                        grant_idx[ch] = CW'(idx);
                        taken[idx]    = 1'b1;
                        rr_next       = (idx + 1 == NUM_CONSUMERS) ? '0 : CW'(idx + 1);
                    end
                end
            end
        end
    end

    // Per-channel FSMs, registered memory requests and consumer responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch] <= StIdle;
                cons_q[ch]  <= '0;
`ifdef DMEMC_TIMEOUT_EN
                timer_q[ch] <= '0;
`endif
            end
            is_read_q           <= '0;
            in_service_q        <= '0;
            rr_ptr_q            <= '0;
            mem_read_valid      <= '0;
            mem_read_address    <= '0;
            write_valid_q       <= '0;
            write_address_q     <= '0;
            write_data_q        <= '0;
            write_ready_q       <= '0;
            consumer_read_ready <= '0;
            consumer_read_data  <= '0;
`ifdef DMEMC_TIMEOUT_EN
            consumer_error      <= '0;
`endif
        end else begin
            rr_ptr_q <= rr_next;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                unique case (state_q[ch])
                    StIdle: begin
                        if (grant_en[ch]) begin
                            cons_q[ch]                  <= grant_idx[ch];
                            in_service_q[grant_idx[ch]] <= 1'b1;
`ifdef DMEMC_TIMEOUT_EN
                            timer_q[ch]                 <= '0;
`endif
                            // Read wins when a consumer illegally asserts both.
                            if (consumer_read_valid[grant_idx[ch]]) begin
                                is_read_q[ch]      <= 1'b1;
                                state_q[ch]        <= StReadWait;
                                mem_read_valid[ch] <= 1'b1;
                                mem_read_address[ch*ADDR_BITS +: ADDR_BITS] <=
                                    consumer_read_address[int'(grant_idx[ch])*ADDR_BITS +: ADDR_BITS];
                            end else begin
                                is_read_q[ch]     <= 1'b0;
                                state_q[ch]       <= StWriteWait;
                                write_valid_q[ch] <= 1'b1;
                                write_address_q[ch*ADDR_BITS +: ADDR_BITS] <=
                                    consumer_write_address[int'(grant_idx[ch])*ADDR_BITS +: ADDR_BITS];
                                write_data_q[ch*DATA_BITS +: DATA_BITS] <=
                                    consumer_write_data[int'(grant_idx[ch])*DATA_BITS +: DATA_BITS];
                            end
                        end
                    end
                    StReadWait: begin
                        if (mem_read_ready[ch]) begin
                            mem_read_valid[ch]              <= 1'b0;
                            consumer_read_ready[cons_q[ch]] <= 1'b1;
                            consumer_read_data[int'(cons_q[ch])*DATA_BITS +: DATA_BITS] <=
                                mem_read_data[ch*DATA_BITS +: DATA_BITS];
                            state_q[ch]                     <= StRelay;
`ifdef DMEMC_TIMEOUT_EN
                        end else if (timer_q[ch] == TimeoutLast) begin
                            mem_read_valid[ch]              <= 1'b0;
                            consumer_read_ready[cons_q[ch]] <= 1'b1;
                            consumer_read_data[int'(cons_q[ch])*DATA_BITS +: DATA_BITS] <= '0;
                            consumer_error[cons_q[ch]]      <= 1'b1;
                            state_q[ch]                     <= StRelay;
                        end else begin
                            timer_q[ch] <= timer_q[ch] + 16'd1;
`endif
                        end
                    end
                    StWriteWait: begin
                        if (mem_write_ready[ch]) begin
                            write_valid_q[ch]         <= 1'b0;
                            write_ready_q[cons_q[ch]] <= 1'b1;
                            state_q[ch]               <= StRelay;
`ifdef DMEMC_TIMEOUT_EN
                        end else if (timer_q[ch] == TimeoutLast) begin
                            write_valid_q[ch]          <= 1'b0;
                            write_ready_q[cons_q[ch]]  <= 1'b1;
                            consumer_error[cons_q[ch]] <= 1'b1;
                            state_q[ch]                <= StRelay;
                        end else begin
                            timer_q[ch] <= timer_q[ch] + 16'd1;
`endif
                        end
                    end
                    StRelay: begin
                        // Hold the response until the served consumer withdraws its request.
                        if (is_read_q[ch] ? !consumer_read_valid[cons_q[ch]]
                                          : !consumer_write_valid[cons_q[ch]]) begin
                            consumer_read_ready[cons_q[ch]] <= 1'b0;
                            write_ready_q[cons_q[ch]]       <= 1'b0;
                            in_service_q[cons_q[ch]]        <= 1'b0;
`ifdef DMEMC_TIMEOUT_EN
                            consumer_error[cons_q[ch]]      <= 1'b0;
`endif
                            state_q[ch]                     <= StIdle;
                        end
                    end
                    default: state_q[ch] <= StIdle;
                endcase
            end
        end
    end

endmodule
